// File: rtl/vid_timing_tx.sv
// ============================================================================
// Module   : vid_timing_tx
// Summary  : ADV7513 raster timing generator and stream-fed pixel output stage.
//            Optional macro VTG_TEST_PATTERN_EN replaces the stream with bars.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vid_timing_tx #(
    parameter int               H_ACTIVE      = 1280,
    parameter int               H_FRONT       = 110,
    parameter int               H_SYNC        = 40,
    parameter int               H_BACK        = 220,
    parameter int               V_ACTIVE      = 720,
    parameter int               V_FRONT       = 5,
    parameter int               V_SYNC        = 5,
    parameter int               V_BACK        = 20,
    parameter bit               HS_POL        = 1'b0,
    parameter bit               VS_POL        = 1'b0,
    parameter int               CH_W          = 8,
    parameter int               LINE_REQ_LEAD = 16,
    parameter logic [3*CH_W-1:0] FILL         = '0
) (
    input  logic                pixel_clk,
    input  logic                reset_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [3*CH_W-1:0]   s_data,
    input  logic                s_sof,
    output logic                line_req_o,
    output logic                frame_start_o,
    output logic                underflow_o,
    output logic                sof_err_o,
    output logic                de,
    output logic                hsync,
    output logic                vsync,
    output logic [CH_W-1:0]     data_r,
    output logic [CH_W-1:0]     data_g,
    output logic [CH_W-1:0]     data_b
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FRONT);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [HW-1:0] H_REQ    = HW'(H_TOTAL - LINE_REQ_LEAD);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_ACT_M1 = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FRONT);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [HW-1:0]       h_cnt;
    logic [VW-1:0]       v_cnt;
    logic [3*CH_W-1:0]   pix;
    logic [3*CH_W-1:0]   pix_next;
    logic                act;
    logic                at_origin;
    logic                hs_on;
    logic                vs_on;
    logic                req_now;
    logic                starve;
    logic                misalign;

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    assign act       = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign at_origin = (h_cnt == '0) && (v_cnt == '0);
    assign hs_on     = (h_cnt >= HS_START) && (h_cnt < HS_END);
    assign vs_on     = (v_cnt >= VS_START) && (v_cnt < VS_END);
    // Request only when the line after this one is active (including wrap to line 0).
    assign req_now   = (h_cnt == H_REQ) && ((v_cnt < V_ACT_M1) || (v_cnt == V_LAST));

`ifdef VTG_TEST_PATTERN_EN
    localparam logic [HW-1:0]   BAR1 = HW'(H_ACTIVE / 4);
    localparam logic [HW-1:0]   BAR2 = HW'(2 * (H_ACTIVE / 4));
    localparam logic [HW-1:0]   BAR3 = HW'(3 * (H_ACTIVE / 4));
    localparam logic [CH_W-1:0] ONES = {CH_W{1'b1}};
    localparam logic [CH_W-1:0] ZERO = {CH_W{1'b0}};

    logic unused_stream;
    assign unused_stream = ^{s_valid, s_sof, s_data};
    assign s_ready       = 1'b0;

    always_comb begin
        pix_next = '0;
        starve   = 1'b0;
        misalign = 1'b0;
        if (act) begin
            if (h_cnt < BAR1)      pix_next = {ZERO, ZERO, ONES};
            else if (h_cnt < BAR2) pix_next = {ZERO, ONES, ZERO};
            else if (h_cnt < BAR3) pix_next = {ONES, ZERO, ZERO};
            else                   pix_next = {ONES, ONES, ONES};
        end
    end
`else
    assign s_ready = act;

    always_comb begin
        pix_next = '0;
        starve   = 1'b0;
        misalign = 1'b0;
        if (act) begin
            if (s_valid) begin
                pix_next = s_data;
                misalign = (s_sof != at_origin);
            end else begin
                pix_next = FILL;
                starve   = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            de            <= 1'b0;
            hsync         <= ~HS_POL;
            vsync         <= ~VS_POL;
            pix           <= '0;
            underflow_o   <= 1'b0;
            sof_err_o     <= 1'b0;
            frame_start_o <= 1'b0;
            line_req_o    <= 1'b0;
        end else begin
            de            <= act;
            hsync         <= hs_on ? HS_POL : ~HS_POL;
            vsync         <= vs_on ? VS_POL : ~VS_POL;
            pix           <= pix_next;
            underflow_o   <= starve;
            sof_err_o     <= misalign;
            frame_start_o <= at_origin;
            line_req_o    <= req_now;
        end
    end

    assign data_r = pix[CH_W-1:0];
    assign data_g = pix[2*CH_W-1:CH_W];
    assign data_b = pix[3*CH_W-1:2*CH_W];

endmodule

`default_nettype wire

// File: tb/tb_vid_timing_tx.sv
// ============================================================================
// Module   : tb_vid_timing_tx
// Summary  : Scoreboard bench for vid_timing_tx on a 16x8 raster.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vid_timing_tx;

    localparam logic [23:0] FILL_C = 24'hA5C3E1;
    localparam logic [30:0] RST_V  = 31'h3000_0000;

    logic        pixel_clk = 1'b0;
    logic        reset_n   = 1'b0;
    logic        s_valid   = 1'b0;
    logic        s_sof     = 1'b0;
    logic [23:0] s_data    = '0;
    logic        s_ready, line_req_o, frame_start_o, underflow_o, sof_err_o;
    logic        de, hsync, vsync;
    logic [7:0]  data_r, data_g, data_b;

    int          total = 0;
    int          bad   = 0;
    int          n     = 0;
    logic [23:0] pix_cnt = 24'h000001;
    logic [30:0] sb[$];

    vid_timing_tx #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CH_W(8), .LINE_REQ_LEAD(4),
        .FILL(FILL_C)
    ) dut (
        .pixel_clk(pixel_clk), .reset_n(reset_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sof(s_sof),
        .line_req_o(line_req_o), .frame_start_o(frame_start_o),
        .underflow_o(underflow_o), .sof_err_o(sof_err_o),
        .de(de), .hsync(hsync), .vsync(vsync),
        .data_r(data_r), .data_g(data_g), .data_b(data_b)
    );

    always #5 pixel_clk = ~pixel_clk;

    // Output vector: {de,hsync,vsync,r,g,b,underflow,sof_err,frame_start,line_req}
    function automatic logic [30:0] model(int h, int v, bit valid, bit sof, logic [23:0] d);
        logic act, hs, vs, uf, se, fs, lr;
        logic [23:0] px;
        act = (h < 8) && (v < 4);
        hs  = !((h >= 10) && (h < 13));
        vs  = !((v >= 5) && (v < 7));
        fs  = (h == 0) && (v == 0);
        lr  = (h == 12) && ((v < 3) || (v == 7));
`ifdef VTG_TEST_PATTERN_EN
        uf = 1'b0;
        se = 1'b0;
        px = 24'h0;
        if (act) px = (h < 2) ? 24'h0000FF : (h < 4) ? 24'h00FF00 :
                      (h < 6) ? 24'hFF0000 : 24'hFFFFFF;
`else
        uf = act && !valid;
        se = act && valid && (sof != fs);
        px = !act ? 24'h0 : (valid ? d : FILL_C);
`endif
        return {act, hs, vs, px[7:0], px[15:8], px[23:16], uf, se, fs, lr};
    endfunction

    function automatic logic exp_ready(int h, int v);
`ifdef VTG_TEST_PATTERN_EN
        return 1'b0;
`else
        return (h < 8) && (v < 4);
`endif
    endfunction

    task automatic drive(input bit valid, input bit sof);
        int h, v;
        h = n % 16;
        v = (n / 16) % 8;
        s_valid = valid;
        s_sof   = sof;
        s_data  = pix_cnt;
        sb.push_back(model(h, v, valid, sof, pix_cnt));
        if (valid && (h < 8) && (v < 4)) pix_cnt = pix_cnt + 24'h010203;
    endtask

    task automatic sample(output logic [30:0] obs);
        @(posedge pixel_clk);
        #1;
        obs = {de, hsync, vsync, data_r, data_g, data_b,
               underflow_o, sof_err_o, frame_start_o, line_req_o};
        n++;
    endtask

    task automatic test_reset();
        logic [30:0] obs;
        repeat (3) @(posedge pixel_clk);
        #1;
        obs = {de, hsync, vsync, data_r, data_g, data_b,
               underflow_o, sof_err_o, frame_start_o, line_req_o};
        total++;
        if (obs !== RST_V) begin
            bad++;
            $display("FAIL reset_vals got=%h want=%h", obs, RST_V);
        end
        total++;
        if (s_ready !== exp_ready(0, 0)) begin
            bad++;
            $display("FAIL reset_ready got=%b want=%b", s_ready, exp_ready(0, 0));
        end
        reset_n = 1'b1;
        n = 0;
    endtask

    task automatic test_raster();
        logic [30:0] obs, exp;
        for (int i = 0; i < 128; i++) begin
            drive(1'b1, (n % 128) == 0);
            total++;
            if (s_ready !== exp_ready(n % 16, (n / 16) % 8)) begin
                bad++;
                $display("FAIL raster_ready n=%0d got=%b want=%b", n, s_ready, ~s_ready);
            end
            sample(obs);
            exp = sb.pop_front();
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL raster n=%0d got=%h want=%h", n - 1, obs, exp);
            end
        end
    endtask

    task automatic test_underflow();
        logic [30:0] obs, exp;
        int h, v, uf_cnt;
        uf_cnt = 0;
        for (int i = 0; i < 128; i++) begin
            h = n % 16;
            v = (n / 16) % 8;
            drive(!((v == 1) && ((h == 3) || (h == 4))), (h == 0) && (v == 0));
            sample(obs);
            exp = sb.pop_front();
            if (obs[3]) uf_cnt++;
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL underflow n=%0d got=%h want=%h", n - 1, obs, exp);
            end
        end
        total++;
        if (uf_cnt !== 2) begin
            bad++;
            $display("FAIL underflow_count got=%0d want=2", uf_cnt);
        end
    endtask

    task automatic test_sof_err();
        logic [30:0] obs, exp;
        int h, v, f, se_cnt;
        se_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            h = n % 16;
            v = (n / 16) % 8;
            f = i / 128;
            drive(1'b1, (f == 0) && (((h == 0) && (v == 0)) || ((h == 2) && (v == 1))));
            sample(obs);
            exp = sb.pop_front();
            if (obs[2]) se_cnt++;
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL sof_err n=%0d got=%h want=%h", n - 1, obs, exp);
            end
        end
        total++;
        if (se_cnt !== 2) begin
            bad++;
            $display("FAIL sof_err_count got=%0d want=2", se_cnt);
        end
    endtask

    task automatic test_line_req();
        logic [30:0] obs, exp;
        logic prev_de;
        int lr_cnt, last_lr;
        lr_cnt  = 0;
        last_lr = -1;
        prev_de = 1'b1;
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, (n % 128) == 0);
            sample(obs);
            exp = sb.pop_front();
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL line_req n=%0d got=%h want=%h", n - 1, obs, exp);
            end
            if (obs[0]) begin
                lr_cnt++;
                last_lr = i;
            end
            if (obs[30] && !prev_de && (last_lr >= 0)) begin
                total++;
                if (i - last_lr !== 4) begin
                    bad++;
                    $display("FAIL line_req_lead got=%0d want=4", i - last_lr);
                end
            end
            prev_de = obs[30];
        end
        total++;
        if (lr_cnt !== 8) begin
            bad++;
            $display("FAIL line_req_count got=%0d want=8", lr_cnt);
        end
    endtask

    task automatic test_mid_reset();
        logic [30:0] obs, exp;
        int guard;
        guard = 0;
        while (((n % 128) != 37) && (guard < 200)) begin
            drive(1'b1, (n % 128) == 0);
            sample(obs);
            exp = sb.pop_front();
            guard++;
        end
        total++;
        if (guard >= 200) begin
            bad++;
            $display("FAIL mid_reset_reach got=%0d want<200", guard);
        end
        reset_n = 1'b0;
        #1;
        obs = {de, hsync, vsync, data_r, data_g, data_b,
               underflow_o, sof_err_o, frame_start_o, line_req_o};
        total++;
        if (obs !== RST_V) begin
            bad++;
            $display("FAIL mid_reset_vals got=%h want=%h", obs, RST_V);
        end
        repeat (3) @(posedge pixel_clk);
        #1;
        total++;
        if (de !== 1'b0 || s_ready !== exp_ready(0, 0)) begin
            bad++;
            $display("FAIL mid_reset_hold got=%b%b want=0%b", de, s_ready, exp_ready(0, 0));
        end
        reset_n = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, (n % 128) == 0);
            sample(obs);
            exp = sb.pop_front();
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL restart n=%0d got=%h want=%h", n - 1, obs, exp);
            end
            if (i == 0) begin
                total++;
                if (!(obs[30] && obs[1])) begin
                    bad++;
                    $display("FAIL restart_first_de de=%b fs=%b want=11", obs[30], obs[1]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_raster();
`ifndef VTG_TEST_PATTERN_EN
        test_underflow();
        test_sof_err();
`endif
        test_line_req();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vid_timing_tx.md
# vid_timing_tx

Parametrised video timing generator and pixel output stage for the ADV7513 HDMI transmitter. It produces DE, HSYNC and VSYNC for any CEA/VESA raster, with programmable sync polarity. It pulls pixels from an upstream valid/ready stream during the active region, fills starved pixels with a fixed colour, and reports stream alignment errors. It sits between the frame-buffer line reader and the ADV7513 pins, entirely in the pixel_clk domain.

## Interface
- H_ACTIVE, 1280, active pixels per line
- H_FRONT, 110, horizontal front porch (pixels)
- H_SYNC, 40, hsync width (pixels)
- H_BACK, 220, horizontal back porch (pixels)
- V_ACTIVE, 720, active lines per frame
- V_FRONT, 5, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BACK, 20, vertical back porch (lines)
- HS_POL, 0, hsync asserted level (0 = active-low)
- VS_POL, 0, vsync asserted level
- CH_W, 8, bits per colour channel
- LINE_REQ_LEAD, 16, cycles before line start that line_req_o pulses; legal range 1..H_TOTAL-H_ACTIVE
- FILL, 0, 3*CH_W fill colour for starved pixels
- pixel_clk  in  1  pixel clock
- reset_n  in  1  asynchronous, active-low reset
- s_valid  in  1  upstream pixel valid
- s_ready  out  1  pixel accepted this cycle when s_valid is also high
- s_data  in  3*CH_W  pixel data, packed {B,G,R}
- s_sof  in  1  marks the first pixel of a frame
- line_req_o  out  1  one-cycle request to the reader for the next active line
- frame_start_o  out  1  one-cycle pulse on the first active pixel of a frame
- underflow_o  out  1  one-cycle pulse per starved active pixel
- sof_err_o  out  1  one-cycle pulse on an s_sof misalignment
- de  out  1  data enable
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- data_r, data_g, data_b  out  CH_W each  pixel channels

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK; V_TOTAL = V_ACTIVE+V_FRONT+V_SYNC+V_BACK.
- Counter widths are $clog2 of the respective total.
- h_cnt runs 0..H_TOTAL-1 and wraps. v_cnt increments on the h_cnt wrap, runs 0..V_TOTAL-1 and wraps.
- Line order is active, front, sync, back. The frame uses the same order in lines.
- act = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE). s_ready = act, decoded combinationally from the counters.
- hsync is asserted when h_cnt is in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC). vsync is asserted when v_cnt is in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC). vsync changes only at h_cnt == 0.
- Pixel path, when act is high:
  - s_valid high: output s_data.
  - s_valid low: output FILL and pulse underflow_o.
  - act low: output 0.
- Alignment check, on each accepted pixel:
  - At h_cnt == 0 and v_cnt == 0, s_sof must be 1.
  - At any other position, s_sof must be 0.
  - Either violation pulses sof_err_o. The pixel is still output; no resynchronisation.
- line_req_o pulses when h_cnt == H_TOTAL-LINE_REQ_LEAD and the next line is active, i.e. v_cnt < V_ACTIVE-1 or v_cnt == V_TOTAL-1.
- frame_start_o pulses at h_cnt == 0, v_cnt == 0.

## Timing
- All outputs except s_ready are registered, so they appear 1 cycle after the counter state that decodes them.
- de, hsync, vsync, data and the status pulses are mutually aligned.
- line_req_o leads the first de of the requested line by exactly LINE_REQ_LEAD cycles.
- Reset, applied asynchronously: h_cnt = v_cnt = 0; de = 0; hsync = !HS_POL; vsync = !VS_POL; data = 0; all pulses 0.
- s_ready is act decoded from the reset counters, so it is 1 during reset. Upstream must not treat transfers during reset as consumed.
- First cycle after reset release: the counters start at (0,0). The first registered de = 1 and frame_start_o occur on the next edge.
- Reset mid-frame aborts the frame. No partial-line recovery is attempted.
- s_data and s_sof are sampled only when s_valid && s_ready. Input values outside that condition are ignored.

## Configuration
- VTG_TEST_PATTERN_EN defined:
  - The stream input is ignored and s_ready is tied to 0.
  - The active region shows four vertical bars of width H_ACTIVE/4: red, green, blue, white at full scale. The last bar absorbs any remainder.
  - underflow_o and sof_err_o are held at 0.
- Undefined: stream path as described in Operation.

## Test plan
Small raster for all tests: H_ACTIVE=8, H_FRONT=2, H_SYNC=3, H_BACK=3, V_ACTIVE=4, V_FRONT=1, V_SYNC=2, V_BACK=1, LINE_REQ_LEAD=4. This gives H_TOTAL=16 and V_TOTAL=8.
- Release reset, s_valid held 1, incrementing data -> per line: de high for 8 cycles, hsync low for 3 cycles starting 10 cycles after de rise; per frame: vsync low for 2 lines starting line 5; data matches the input sequence.
- s_valid held low for pixels 3..4 of line 1 -> FILL on those pixels, underflow_o high for exactly 2 cycles, de unaffected.
- s_sof = 1 on pixel (2,1), and s_sof = 0 on pixel (0,0) of the next frame -> sof_err_o pulses at both positions.
- Monitor line_req_o for two frames -> 4 pulses per frame, each exactly 4 cycles before a de rising edge; none before blank lines.
- Assert reset_n at mid-line 2 for 3 cycles -> outputs take their reset values immediately; the raster restarts at (0,0) with frame_start_o on the first de.
- Compile with VTG_TEST_PATTERN_EN -> s_ready = 0; pixels 0-1 = FF0000 (R), 2-3 = 00FF00 (G), 4-5 = 0000FF (B), 6-7 = FFFFFF (white), in {R,G,B} notation.
